mem_ctrl_uart_arb: RTL and testbench
====================================

// Module: mem_ctrl_uart_arb
// PURPOSE
//  Multi-channel memory controller (north bridge) over a byte-wide UART link.
//  Arbitrates NCH cache/CPU clients round-robin, serialises one request at a time into a byte frame
//  (header, address, write data), and collects read-data bytes back into the client's read register.
//  Sits between the cache ports and the UART byte transceiver. Successor to the single-client controller:
//  parametrised width and channel count, fully synchronous handshakes.
// PARAMETERS
//  NCH     2   number of client channels (1..8)
//  ADDR_W  32  client address width; multiple of 8; ADDR_B = ADDR_W/8 address bytes per frame
//  DATA_W  32  client data width; multiple of 8, max 32; DATA_B = DATA_W/8
// PORTS
//  clk      in   1            clock, all logic on posedge
//  rst      in   1            asynchronous, active-low reset
//  c_re     in   NCH          per-channel read request, level, held until c_rack
//  c_we     in   NCH          per-channel write request, level, held until c_wack
//  c_raddr  in   NCH*ADDR_W   read address, channel k at [k*ADDR_W +: ADDR_W]
//  c_waddr  in   NCH*ADDR_W   write address
//  c_rlen   in   NCH*2        read length minus 1 (bytes), per channel
//  c_wlen   in   NCH*2        write length minus 1 (bytes), per channel
//  c_din    in   NCH*DATA_W   write data, byte 0 = LSB
//  c_dout   out  NCH*DATA_W   read data register per channel
//  c_rack   out  NCH          one-cycle read-done pulse
//  c_wack   out  NCH          one-cycle write-done pulse
//  u_dout   out  8            byte to link
//  u_we     out  1            byte valid; held with u_dout stable until u_wack
//  u_wack   in   1            one-cycle: link accepted u_dout
//  u_din    in   8            byte from link, valid when u_rack
//  u_re     out  1            byte wanted; held until u_rack
//  u_rack   in   1            one-cycle: u_din valid
//  busy     out  1            frame in progress
// BEHAVIOUR
//  Reset: all outputs 0, c_dout registers 0, state IDLE, RR pointer = NCH-1 (channel 0 first).
//  Reset mid-frame aborts immediately; no ack is issued; link resync is the far side's duty.
//  Frame: HDR = {rw(1=read),5'b0,len[1:0]}; then ADDR_B addr bytes LSB first; write: len+1 data bytes LSB first;
//    read: len+1 bytes received LSB first. len clamped to DATA_B-1.
//  FSM: IDLE -> HDR -> ADDR -> (WDATA | RDATA) -> DONE -> IDLE.
//   IDLE: if any (c_re|c_we) and no ack pulsed last cycle on that channel, grant first requester after RR pointer;
//     latch ch, rw, addr, len, wdata; load HDR into u_dout, u_we=1 next cycle; pointer := ch; busy=1.
//   HDR/ADDR/WDATA: advance byte counter on u_wack; u_we drops for exactly 0 cycles between bytes (next byte
//     loaded on the u_wack edge). Counter resets on each phase change.
//   RDATA: u_re=1; on u_rack store u_din into byte[cnt] of a staging reg; after len+1 bytes go DONE, u_re=0.
//   DONE (1 cycle): read -> c_dout[ch] := staging, upper bytes zero; c_rack[ch]=1. write -> c_wack[ch]=1. busy=0.
//  Same channel c_re and c_we both high: read served first; write remains pending for later arbitration.
//  Latched request fields are used for the whole frame; client changes after grant are ignored.
//  Request dropped before ack: frame still completes, ack still pulsed (client must ignore).
//  Client must deassert request the cycle after ack; the controller masks that channel for 1 cycle after ack.
//  Minimum latency, zero-wait link: write 1+1+ADDR_B+len+1 cycles request-to-ack; read same with RDATA.
//  c_dout[k] is stable except in the DONE cycle of a read on channel k.
// STRUCTURE
//  def.v: frame header bit positions, FSM state encodings, byte width 8, len width 2.
//  Sub-module rr_arbiter #(N): req[N], ptr -> one-hot grant + index; combinational, instantiated once.
//  Per-channel field selection via generate-indexed part-selects; single frame engine, no per-channel FSM.
// TESTING
//  ch0 write a=0x00001000 d=0xDEADBEEF wlen=3 -> bytes 03,00,10,00,00,EF,BE,AD,DE; one c_wack[0] pulse.
//  ch1 read a=0x20 rlen=1, link returns 34,12 -> header 81,20,00,00,00; c_dout[1]=0x00001234, c_rack[1] pulse.
//  ch0+ch1 requests same cycle, held: grants ch0, ch1, ch0 alternate (RR); no starvation over 6 frames.
//  wlen=3 with DATA_W=16 -> clamped, header len=1, 2 data bytes sent.
//  rst low mid-ADDR phase -> u_we, busy, acks 0 next edge; after release new request starts fresh at HDR.
//  Link stalls u_wack 5 cycles per byte -> u_dout stable throughout; frame contents unchanged.

Source files
------------

// File: rtl/mem_ctrl_uart_arb_pkg.sv
// Shared definitions for the UART-link memory controller: frame header
// layout, field widths and frame-engine state encodings.
package mem_ctrl_uart_arb_pkg;

  localparam int BYTE_W     = 8;
  localparam int LEN_W      = 2;
  localparam int CNT_W      = 8;
  localparam int HDR_RW_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } state_e;

  // Header byte: read/write flag in the MSB, (length-1) in the low bits.
  function automatic logic [BYTE_W-1:0] make_hdr(input logic rw, input logic [LEN_W-1:0] len);
    logic [BYTE_W-1:0] h;
    h             = '0;
    h[HDR_RW_BIT] = rw;
    h[LEN_W-1:0]  = len;
    return h;
  endfunction

  // A client may ask for more bytes than the data width holds; cap it.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/mem_ctrl_uart_arb_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly
// after the pointer, wrapping around, so the pointer channel goes last.
module mem_ctrl_uart_arb_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  // Scan channels ptr+1 .. ptr+N (mod N) and take the first requester.
  always_comb begin
    int  c;
    logic found;
    c     = 0;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(ptr_i) + i) % N;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/mem_ctrl_uart_arb.sv
// Multi-client memory controller over a byte-wide UART link. One frame
// engine serialises the granted request (header, address, write data) and
// gathers read-data bytes back into that client's read register.
module mem_ctrl_uart_arb
  import mem_ctrl_uart_arb_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NCH-1:0]        c_re_i,
  input  logic [NCH-1:0]        c_we_i,
  input  logic [NCH*ADDR_W-1:0] c_raddr_i,
  input  logic [NCH*ADDR_W-1:0] c_waddr_i,
  input  logic [NCH*LEN_W-1:0]  c_rlen_i,
  input  logic [NCH*LEN_W-1:0]  c_wlen_i,
  input  logic [NCH*DATA_W-1:0] c_din_i,
  output logic [NCH*DATA_W-1:0] c_dout_o,
  output logic [NCH-1:0]        c_rack_o,
  output logic [NCH-1:0]        c_wack_o,
  output logic [BYTE_W-1:0]     u_dout_o,
  output logic                  u_we_o,
  input  logic                  u_wack_i,
  input  logic [BYTE_W-1:0]     u_din_i,
  output logic                  u_re_o,
  input  logic                  u_rack_i,
  output logic                  busy_o
);

  localparam int ADDR_B = ADDR_W / BYTE_W;
  localparam int DATA_B = DATA_W / BYTE_W;
  localparam int IW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_B - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, nxt;
  logic [IW-1:0]         ch_q, ch_d, ptr_q, ptr_d;
  logic                  rw_q, rw_d;
  logic [ADDR_W-1:0]     addr_q, addr_d, addr_sh;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d, wdata_sh, stage_q, stage_d;
  logic [NCH-1:0]        mask_q, mask_d, ch_onehot;
  logic [NCH*DATA_W-1:0] dout_q, dout_d;
  logic [BYTE_W-1:0]     u_dout_q, u_dout_d;
  logic                  u_we_q, u_we_d, u_re_q, u_re_d;

  logic [ADDR_W-1:0] raddr_a [NCH];
  logic [ADDR_W-1:0] waddr_a [NCH];
  logic [LEN_W-1:0]  rlen_a  [NCH];
  logic [LEN_W-1:0]  wlen_a  [NCH];
  logic [DATA_W-1:0] din_a   [NCH];

  logic [NCH-1:0]    gnt;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_vld, sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [DATA_W-1:0] sel_din;

  // Unpack the flat per-channel buses and drive the read-data registers out.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign raddr_a[gi] = c_raddr_i[gi*ADDR_W +: ADDR_W];
    assign waddr_a[gi] = c_waddr_i[gi*ADDR_W +: ADDR_W];
    assign rlen_a[gi]  = c_rlen_i[gi*LEN_W +: LEN_W];
    assign wlen_a[gi]  = c_wlen_i[gi*LEN_W +: LEN_W];
    assign din_a[gi]   = c_din_i[gi*DATA_W +: DATA_W];
    assign c_dout_o[gi*DATA_W +: DATA_W] = dout_q[gi*DATA_W +: DATA_W];
  end

  // A channel acked last cycle is masked so its stale request is not regranted.
  mem_ctrl_uart_arb_rr_arbiter #(.N(NCH), .IW(IW)) u_arb (
    .req_i (( c_re_i | c_we_i ) & ~mask_q),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  // Select the granted channel's fields; a pending read beats a write.
  always_comb begin
    sel_rw   = |(c_re_i & gnt);
    sel_addr = '0;
    sel_len  = '0;
    sel_din  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt[k]) begin
        sel_addr = sel_rw ? raddr_a[k] : waddr_a[k];
        sel_len  = clamp_len(sel_rw ? rlen_a[k] : wlen_a[k], LEN_MAX);
        sel_din  = din_a[k];
      end
    end
  end

  assign ch_onehot = NCH'(1) << ch_q;
  assign c_rack_o  = (state_q == ST_DONE &&  rw_q) ? ch_onehot : '0;
  assign c_wack_o  = (state_q == ST_DONE && !rw_q) ? ch_onehot : '0;
  assign busy_o    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign u_dout_o  = u_dout_q;
  assign u_we_o    = u_we_q;
  assign u_re_o    = u_re_q;

  // Frame engine next state: next byte is loaded on the accepting edge so u_we never gaps.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    len_d    = len_q;
    wdata_d  = wdata_q;
    stage_d  = stage_q;
    ptr_d    = ptr_q;
    mask_d   = '0;
    dout_d   = dout_q;
    u_dout_d = u_dout_q;
    u_we_d   = u_we_q;
    u_re_d   = u_re_q;
    nxt      = cnt_q + 1'b1;
    addr_sh  = addr_q >> (BYTE_W * int'(nxt));
    wdata_sh = wdata_q >> (BYTE_W * int'(nxt));
    unique case (state_q)
      ST_IDLE: if (gnt_vld) begin
        ch_d     = gnt_idx;
        ptr_d    = gnt_idx;
        rw_d     = sel_rw;
        addr_d   = sel_addr;
        len_d    = sel_len;
        wdata_d  = sel_din;
        stage_d  = '0;
        cnt_d    = '0;
        u_dout_d = make_hdr(sel_rw, sel_len);
        u_we_d   = 1'b1;
        state_d  = ST_HDR;
      end
      ST_HDR: if (u_wack_i) begin
        cnt_d    = '0;
        u_dout_d = addr_q[BYTE_W-1:0];
        state_d  = ST_ADDR;
      end
      ST_ADDR: if (u_wack_i) begin
        if (cnt_q == CNT_W'(ADDR_B - 1)) begin
          cnt_d = '0;
          if (rw_q) begin
            u_we_d  = 1'b0;
            u_re_d  = 1'b1;
            state_d = ST_RDATA;
          end else begin
            u_dout_d = wdata_q[BYTE_W-1:0];
            state_d  = ST_WDATA;
          end
        end else begin
          cnt_d    = nxt;
          u_dout_d = addr_sh[BYTE_W-1:0];
        end
      end
      ST_WDATA: if (u_wack_i) begin
        if (cnt_q == CNT_W'(len_q)) begin
          cnt_d   = '0;
          u_we_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d    = nxt;
          u_dout_d = wdata_sh[BYTE_W-1:0];
        end
      end
      ST_RDATA: if (u_rack_i) begin
        stage_d[int'(cnt_q)*BYTE_W +: BYTE_W] = u_din_i;
        if (cnt_q == CNT_W'(len_q)) begin
          cnt_d   = '0;
          u_re_d  = 1'b0;
          dout_d[int'(ch_q)*DATA_W +: DATA_W] = stage_d;
          state_d = ST_DONE;
        end else begin
          cnt_d = nxt;
        end
      end
      ST_DONE: begin
        mask_d  = ch_onehot;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any frame in flight without acking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ch_q     <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      wdata_q  <= '0;
      stage_q  <= '0;
      ptr_q    <= IW'(NCH - 1);
      mask_q   <= '0;
      dout_q   <= '0;
      u_dout_q <= '0;
      u_we_q   <= 1'b0;
      u_re_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      wdata_q  <= wdata_d;
      stage_q  <= stage_d;
      ptr_q    <= ptr_d;
      mask_q   <= mask_d;
      dout_q   <= dout_d;
      u_dout_q <= u_dout_d;
      u_we_q   <= u_we_d;
      u_re_q   <= u_re_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl_uart_arb.sv
// Directed bench: link model on the falling edge checks every byte and ack
// against scoreboard queues filled when each request is driven.
module tb_mem_ctrl_uart_arb;

  typedef struct {
    int          ch;
    logic        rw;
    logic [31:0] dout;
  } ack_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  c_re, c_we, c_rack, c_wack;
  logic [63:0] c_raddr, c_waddr, c_din, c_dout;
  logic [3:0]  c_rlen, c_wlen;
  logic [7:0]  u_dout, u_din;
  logic        u_we, u_wack, u_re, u_rack, busy;

  // Narrow instance (16-bit data, 8-bit address) for the length clamp.
  logic        b_we, b_re, b_rack, b_wack, b_uwe, b_ure, b_busy;
  logic [7:0]  b_raddr, b_waddr, b_udout, b_udin;
  logic [1:0]  b_rlen, b_wlen;
  logic [15:0] b_din, b_dout;
  logic        b_urack;

  int errs   = 0;
  int checks = 0;
  int stall  = 0;
  int ack_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rd_q[$];
  ack_t       ack_q[$];

  mem_ctrl_uart_arb #(.NCH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .c_re_i(c_re), .c_we_i(c_we), .c_raddr_i(c_raddr), .c_waddr_i(c_waddr),
    .c_rlen_i(c_rlen), .c_wlen_i(c_wlen), .c_din_i(c_din), .c_dout_o(c_dout),
    .c_rack_o(c_rack), .c_wack_o(c_wack),
    .u_dout_o(u_dout), .u_we_o(u_we), .u_wack_i(u_wack), .u_din_i(u_din),
    .u_re_o(u_re), .u_rack_i(u_rack), .busy_o(busy)
  );

  assign b_urack = 1'b0;
  assign b_udin  = 8'h00;
  mem_ctrl_uart_arb #(.NCH(1), .ADDR_W(8), .DATA_W(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .c_re_i(b_re), .c_we_i(b_we), .c_raddr_i(b_raddr), .c_waddr_i(b_waddr),
    .c_rlen_i(b_rlen), .c_wlen_i(b_wlen), .c_din_i(b_din), .c_dout_o(b_dout),
    .c_rack_o(b_rack), .c_wack_o(b_wack),
    .u_dout_o(b_udout), .u_we_o(b_uwe), .u_wack_i(b_uwe), .u_din_i(b_udin),
    .u_re_o(b_ure), .u_rack_i(b_urack), .busy_o(b_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected link bytes of one frame (len already clamped by the caller).
  task automatic push_frame(input logic rw, input logic [31:0] a, input logic [1:0] len,
                            input logic [31:0] d);
    exp_q.push_back({rw, 5'b00000, len});
    for (int i = 0; i < 4; i++) exp_q.push_back(a[i*8 +: 8]);
    if (!rw) for (int i = 0; i <= int'(len); i++) exp_q.push_back(d[i*8 +: 8]);
  endtask

  task automatic push_ack(input int ch, input logic rw, input logic [31:0] d);
    ack_t a;
    a.ch = ch; a.rw = rw; a.dout = d;
    ack_q.push_back(a);
  endtask

  task automatic set_wr(input int ch, input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
    c_waddr[ch*32 +: 32] = a;
    c_wlen[ch*2 +: 2]    = l;
    c_din[ch*32 +: 32]   = d;
  endtask

  task automatic set_rd(input int ch, input logic [31:0] a, input logic [1:0] l);
    c_raddr[ch*32 +: 32] = a;
    c_rlen[ch*2 +: 2]    = l;
  endtask

  task automatic wait_acks(input int target);
    int n;
    n = 0;
    while (ack_cnt < target && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    check("ack_timeout", (ack_cnt >= target), 1);
  endtask

  // Link far side and ack scoreboard, sampled on the falling edge.
  initial begin : link_model
    int         wcnt;
    logic [7:0] held;
    logic [8:0] e;
    ack_t       a;
    wcnt = 0; held = '0;
    u_wack = 1'b0; u_rack = 1'b0; u_din = 8'h00;
    forever begin
      @(negedge clk);
      u_wack = 1'b0;
      u_rack = 1'b0;
      if (u_we) begin
        if (wcnt == 0) held = u_dout;
        else check("u_dout_stable", u_dout, held);
        if (wcnt >= stall) begin
          if (exp_q.size() > 0) e = {1'b0, exp_q.pop_front()};
          else e = 9'h100;
          check("link_byte", {1'b0, u_dout}, e);
          u_wack = 1'b1;
          wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
      if (u_re) begin
        if (rd_q.size() > 0) u_din = rd_q.pop_front();
        else check("rd_q_size", rd_q.size(), 1);
        u_rack = 1'b1;
      end
      for (int ch = 0; ch < 2; ch++) begin
        if (c_rack[ch] || c_wack[ch]) begin
          if (ack_q.size() > 0) begin
            a = ack_q.pop_front();
            check("ack_ch", ch, a.ch);
            check("ack_rw", c_rack[ch], a.rw);
            if (a.rw) check("c_dout", c_dout[ch*32 +: 32], a.dout);
          end else check("ack_q_size", ack_q.size(), 1);
          ack_cnt++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] got[$];
    logic [7:0] bexp[4];
    int         back;
    int         base;
    rst_n = 1'b0;
    c_re = '0; c_we = '0; c_raddr = '0; c_waddr = '0; c_rlen = '0; c_wlen = '0; c_din = '0;
    b_re = 1'b0; b_we = 1'b0; b_raddr = '0; b_waddr = '0; b_rlen = '0; b_wlen = '0; b_din = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_u_we", u_we, 0);
    check("rst_busy", busy, 0);
    check("rst_acks", {c_rack, c_wack}, 0);
    check("rst_c_dout", c_dout, 0);
    check("rst_u_re", u_re, 0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Length clamp on the 16-bit instance: wlen=3 becomes 1.
    b_waddr = 8'h07; b_wlen = 2'd3; b_din = 16'hBEEF; b_we = 1'b1;
    bexp[0] = 8'h01; bexp[1] = 8'h07; bexp[2] = 8'hEF; bexp[3] = 8'hBE;
    back = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (b_uwe) got.push_back(b_udout);
      if (b_wack) begin back++; b_we = 1'b0; end
    end
    check("clamp_nbytes", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("clamp_byte", got[i], bexp[i]);
    check("clamp_wack", back, 1);

    // ch0 write with literal frame bytes.
    exp_q.push_back(8'h03); exp_q.push_back(8'h00); exp_q.push_back(8'h10);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE); exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
    push_ack(0, 1'b0, 32'h0);
    set_wr(0, 32'h0000_1000, 2'd3, 32'hDEAD_BEEF);
    c_we[0] = 1'b1;
    base = ack_cnt;
    @(negedge clk); @(negedge clk); #1;
    check("busy_in_frame", busy, 1);
    wait_acks(base + 1);
    c_we[0] = 1'b0;
    check("busy_in_done", busy, 0);

    // ch1 read of two bytes.
    push_frame(1'b1, 32'h20, 2'd1, 32'h0);
    rd_q.push_back(8'h34); rd_q.push_back(8'h12);
    push_ack(1, 1'b1, 32'h0000_1234);
    set_rd(1, 32'h20, 2'd1);
    c_re[1] = 1'b1;
    base = ack_cnt;
    wait_acks(base + 1);
    c_re[1] = 1'b0;
    check("c_dout0_untouched", c_dout[31:0], 32'h0);

    // Both channels held: grants must alternate 0,1,0,1,0,1.
    set_wr(0, 32'h100, 2'd0, 32'h1122_3344);
    set_wr(1, 32'h200, 2'd1, 32'h5566_7788);
    for (int i = 0; i < 3; i++) begin
      push_frame(1'b0, 32'h100, 2'd0, 32'h1122_3344); push_ack(0, 1'b0, 32'h0);
      push_frame(1'b0, 32'h200, 2'd1, 32'h5566_7788); push_ack(1, 1'b0, 32'h0);
    end
    c_we = 2'b11;
    base = ack_cnt;
    wait_acks(base + 6);
    c_we = 2'b00;

    // Same channel read and write together: read served first.
    push_frame(1'b1, 32'h40, 2'd0, 32'h0);
    rd_q.push_back(8'h5A);
    push_ack(0, 1'b1, 32'h0000_005A);
    push_frame(1'b0, 32'h50, 2'd0, 32'h0000_00AA);
    push_ack(0, 1'b0, 32'h0);
    set_rd(0, 32'h40, 2'd0);
    set_wr(0, 32'h50, 2'd0, 32'h0000_00AA);
    c_re[0] = 1'b1; c_we[0] = 1'b1;
    base = ack_cnt;
    wait_acks(base + 1);
    c_re[0] = 1'b0;
    wait_acks(base + 2);
    c_we[0] = 1'b0;

    // Stalled link: every byte waits 5 cycles for u_wack.
    stall = 5;
    push_frame(1'b0, 32'hCAFE_0001, 2'd2, 32'h0BAD_F00D);
    push_ack(1, 1'b0, 32'h0);
    set_wr(1, 32'hCAFE_0001, 2'd2, 32'h0BAD_F00D);
    c_we[1] = 1'b1;
    base = ack_cnt;
    wait_acks(base + 1);
    c_we[1] = 1'b0;
    stall = 0;

    // Reset in the middle of the address phase.
    push_frame(1'b0, 32'h0000_4000, 2'd0, 32'h0000_0099);
    set_wr(0, 32'h0000_4000, 2'd0, 32'h0000_0099);
    c_we[0] = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    check("busy_before_abort", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_u_we", u_we, 0);
    check("abort_busy", busy, 0);
    check("abort_acks", {c_rack, c_wack}, 0);
    check("abort_c_dout", c_dout, 0);
    exp_q.delete();
    c_we[0] = 1'b0;
    @(negedge clk); #1;
    check("abort_no_ack", ack_cnt, base + 1);
    rst_n = 1'b1;
    push_frame(1'b0, 32'h0000_3000, 2'd0, 32'h0000_0077);
    push_ack(1, 1'b0, 32'h0);
    set_wr(1, 32'h0000_3000, 2'd0, 32'h0000_0077);
    c_we[1] = 1'b1;
    base = ack_cnt;
    wait_acks(base + 1);
    c_we[1] = 1'b0;

    repeat (4) @(negedge clk);
    #1;
    check("exp_bytes_left", exp_q.size(), 0);
    check("rd_bytes_left", rd_q.size(), 0);
    check("acks_left", ack_q.size(), 0);
    check("idle_at_end", busy, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
